// File: rtl/dm_pkg.sv
// dm_pkg -- shared definitions for the dm_banked data memory.
//   Size encodings, byte-enable width, error-cause bit positions,
//   FSM state type, response register type and an alignment helper.
package dm_pkg;

  localparam int BE_W = 4;  // bytes per 32-bit word

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // bit positions inside the per-request error-cause vector
  localparam int ERR_SIZE  = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RANGE = 2;
  localparam int ERR_W     = 3;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} dm_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dm_rsp_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/dm_banked_if.sv
// dm_banked_if -- request/response bus of dm_banked.
//   req_*  : valid/ready request channel (store or load, byte address, size)
//   rsp_*  : valid/ready response channel (load data, error flag)
//   master : requester side, slave : memory side.
interface dm_banked_if #(parameter int ADDR_W = 14);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt -- combinational byte-lane formatting.
//   size/lane   : access size and req_addr[1:0]
//   ld_signed   : sign-extend sub-word loads
//   wdata       : right-aligned store data
//   rword       : stored word read from the array
//   be          : byte enables for a store
//   wsh         : store data placed on its byte lanes
//   ld_data     : extracted, extended load result
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            lane,
  input  logic                  ld_signed,
  input  logic [31:0]           wdata,
  input  logic [31:0]           rword,
  output logic [BE_W-1:0]       be,
  output logic [BE_W-1:0][7:0]  wsh,
  output logic [31:0]           ld_data
);
  logic [BE_W-1:0] be_base;
  logic [31:0]     sh;

  always_comb begin
    be_base = '0;
    case (size)
      SZ_BYTE: be_base = 4'b0001;
      SZ_HALF: be_base = 4'b0011;
      SZ_WORD: be_base = 4'b1111;
      default: be_base = 4'b0000;
    endcase
  end

  assign be = be_base << lane;

  // Replicate the right-aligned data onto every lane it could land on;
  // the byte enables pick the lanes actually written.
  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    always_comb begin
      case (size)
        SZ_BYTE: wsh[l] = wdata[7:0];
        SZ_HALF: wsh[l] = wdata[8*(l%2) +: 8];
        default: wsh[l] = wdata[8*l +: 8];
      endcase
    end
  end

  assign sh = rword >> {lane, 3'b000};

  always_comb begin
    ld_data = '0;
    case (size)
      SZ_BYTE: ld_data = {{24{ld_signed & sh[7]}}, sh[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & sh[15]}}, sh[15:0]};
      SZ_WORD: ld_data = rword;
      default: ld_data = '0;
    endcase
  end
endmodule

// File: rtl/dm_banked.sv
// dm_banked -- single-port 32-bit data memory with byte/half/word access.
//   clk, rst_n : clock, async active-low reset
//   bus        : dm_banked_if slave (request in, registered response out)
//   busy       : high while the post-reset zeroing sweep runs
// After reset the array is swept to zero one word per cycle; requests are
// then served with a one-cycle registered response.
module dm_banked
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_banked_if.slave  bus,
  output logic        busy
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_e         state;
  logic [AW-1:0]     clr_cnt;
  logic              rsp_vld;
  dm_rsp_t           rsp_q;

  logic [IDX_W-1:0]  idx;
  logic [AW-1:0]     widx;
  logic [1:0]        lane;
  logic [ERR_W-1:0]  err;
  logic              accept;
  logic [31:0]       rword;
  logic [BE_W-1:0]   be;
  logic [BE_W-1:0][7:0] wsh;
  logic [31:0]       ld_data;

  assign idx  = bus.req_addr[ADDR_W-1:2];
  assign widx = idx[AW-1:0];  // only used once the range check has passed
  assign lane = bus.req_addr[1:0];

  assign err[ERR_SIZE]  = (bus.req_size == SZ_ILL);
  assign err[ERR_ALIGN] = misaligned(bus.req_size, lane);
  assign err[ERR_RANGE] = (32'(idx) >= 32'(DEPTH_WORDS));

  assign bus.req_ready = (state == ST_RUN) && (!rsp_vld || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign rword = mem[widx];

  dm_lane_fmt u_fmt (
    .size      (bus.req_size),
    .lane      (lane),
    .ld_signed (bus.req_signed),
    .wdata     (bus.req_wdata),
    .rword     (rword),
    .be        (be),
    .wsh       (wsh),
    .ld_data   (ld_data)
  );

  // Array has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && bus.req_we && err == '0) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wsh[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
      rsp_vld <= 1'b0;
      rsp_q   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            state   <= ST_RUN;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            rsp_vld     <= 1'b1;
            rsp_q.err   <= |err;
            rsp_q.rdata <= (|err || bus.req_we) ? 32'd0 : ld_data;
          end else if (bus.rsp_ready) begin
            rsp_vld <= 1'b0;
            rsp_q   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dm_banked.sv
// tb_dm_banked -- randomized self-checking bench for dm_banked.
// The reference model keeps memory as a flat byte array and derives each
// response from the access rules directly.
module tb_dm_banked;
  localparam int DEPTH = 16;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  dm_banked_if #(.ADDR_W(AW)) bus ();

  dm_banked #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  mm [DEPTH*4];
  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mm_clear();
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
  endfunction

  // Behavioural reference: applies one accepted request, returns its response.
  function automatic void model(input bit we, input logic [7:0] a, input logic [1:0] sz,
                                input bit sg, input logic [31:0] wd,
                                output logic [31:0] ed, output bit ee);
    int n;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ee = (sz == 2'd3) || ((int'(a) % n) != 0) || ((int'(a) / 4) >= DEPTH);
    ed = 32'd0;
    if (ee) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) ed |= 32'(mm[int'(a) + i]) << (8*i);
      if (sg && n < 4 && ed[8*n-1]) ed |= ~((32'd1 << (8*n)) - 32'd1);
    end
  endfunction

  // Called just after a negedge; returns at the negedge following acceptance
  // with the response checked there, so consecutive calls issue 1/cycle.
  task automatic xfer(input bit we, input logic [7:0] a, input logic [1:0] sz,
                      input bit sg, input logic [31:0] wd);
    logic [31:0] ed;
    bit ee;
    int t;
    bus.req_we = we; bus.req_addr = a; bus.req_size = sz;
    bus.req_signed = sg; bus.req_wdata = wd; bus.req_valid = 1'b1;
    t = 0;
    #1;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!bus.req_ready) begin
      chk("req_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    model(we, a, sz, sg, wd, ed, ee);
    @(negedge clk);
    bus.req_valid = 1'b0;
    last_rd  = bus.rsp_rdata;
    last_err = bus.rsp_err;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_rdata", bus.rsp_rdata, ed);
    chk("rsp_err",   32'(bus.rsp_err), 32'(ee));
  endtask

  task automatic wait_sweep();
    int cnt;
    bit saw_rdy;
    cnt = 0; saw_rdy = 0;
    while (busy && cnt < 100) begin
      if (bus.req_ready) saw_rdy = 1;
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(cnt), 32'(DEPTH));
    chk("rdy_in_clear", 32'(saw_rdy), 32'd0);
    chk("rdy_after_clear", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed0, ed1, hold_rd;
    bit ee0, ee1, hold_err;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_size = 0;
    bus.req_signed = 0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    mm_clear();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err",   32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    wait_sweep();
    for (int w = 0; w < DEPTH; w++) xfer(0, 8'(w*4), 2'd2, 0, 32'd0);

    // signed/unsigned sub-word loads
    xfer(1, 8'h10, 2'd2, 0, 32'h8899AABB);
    xfer(0, 8'h13, 2'd0, 1, 32'd0); chk("ldb_s", last_rd, 32'hFFFFFF88);
    xfer(0, 8'h13, 2'd0, 0, 32'd0); chk("ldb_u", last_rd, 32'h00000088);
    xfer(0, 8'h10, 2'd1, 1, 32'd0); chk("ldh_s", last_rd, 32'hFFFFAABB);

    // byte merge into an existing word
    xfer(1, 8'h20, 2'd2, 0, 32'h11223344);
    xfer(1, 8'h21, 2'd0, 0, 32'h0000005A);
    xfer(0, 8'h20, 2'd2, 0, 32'd0); chk("merge", last_rd, 32'h11225A44);

    // error cases, stores included to prove no memory write
    xfer(0, 8'h02, 2'd2, 0, 32'd0); chk("e_wmis", {last_rd[30:0], last_err}, 32'd1);
    xfer(0, 8'h03, 2'd1, 0, 32'd0); chk("e_hmis", {last_rd[30:0], last_err}, 32'd1);
    xfer(0, 8'h10, 2'd3, 0, 32'd0); chk("e_size", {last_rd[30:0], last_err}, 32'd1);
    xfer(0, 8'h40, 2'd2, 0, 32'd0); chk("e_range", {last_rd[30:0], last_err}, 32'd1);
    xfer(1, 8'h12, 2'd2, 0, 32'hFFFFFFFF);
    xfer(1, 8'h11, 2'd1, 0, 32'hFFFFFFFF);
    xfer(1, 8'h10, 2'd3, 0, 32'hFFFFFFFF);
    xfer(1, 8'h40, 2'd2, 0, 32'hFFFFFFFF);
    xfer(0, 8'h10, 2'd2, 0, 32'd0); chk("e_nowr10", last_rd, 32'h8899AABB);
    xfer(0, 8'h00, 2'd2, 0, 32'd0); chk("e_nowr00", last_rd, 32'd0);

    // response backpressure
    @(negedge clk);
    chk("rsp_drained", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
    bus.req_we = 0; bus.req_addr = 8'h10; bus.req_size = 2'd2; bus.req_signed = 0;
    bus.req_valid = 1'b1;
    model(0, 8'h10, 2'd2, 0, 32'd0, ed0, ee0);
    @(negedge clk);
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rdata", bus.rsp_rdata, ed0);
    hold_rd = bus.rsp_rdata; hold_err = bus.rsp_err;
    bus.req_addr = 8'h20;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("bp_hold_v", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_d", bus.rsp_rdata, hold_rd);
      chk("bp_hold_e", 32'(bus.rsp_err), 32'(hold_err));
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_ready_up", 32'(bus.req_ready), 32'd1);
    model(0, 8'h20, 2'd2, 0, 32'd0, ed1, ee1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_next_v", 32'(bus.rsp_valid), 32'd1);
    chk("bp_next_d", bus.rsp_rdata, ed1);
    for (int w = 0; w < 8; w++) xfer(0, 8'(w*4), 2'd2, 0, 32'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(bus.rsp_valid), 32'd0);
      end
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 8'h47)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    // reset in RUN with a response pending
    xfer(1, 8'h24, 2'd2, 0, 32'hDEADBEEF);
    bus.rsp_ready = 1'b0;
    bus.req_we = 0; bus.req_addr = 8'h24; bus.req_size = 2'd2; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_pending", 32'(bus.rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_busy",  32'(busy), 32'd1);
    chk("mid_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    mm_clear();
    wait_sweep();
    xfer(0, 8'h24, 2'd2, 0, 32'd0); chk("mid_zeroed", last_rd, 32'd0);
    for (int w = 0; w < DEPTH; w++) xfer(0, 8'(w*4), 2'd2, 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_banked.md
DM_BANKED -- requirements
Module: dm_banked

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072; number of 32-bit words stored.
REQ-002 Parameter ADDR_W, default 14; byte-address width, SHALL satisfy 2^(ADDR_W-2) >= DEPTH_WORDS.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  request accepted when req_valid && req_ready at clk edge.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_addr  input  ADDR_W  byte address.
REQ-009 Port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 Port req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-011 Port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at clk edge.
REQ-014 Port rsp_rdata  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  request was misaligned, out of range or illegal size.
REQ-016 Port busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-017 FSM states: CLEAR, RUN; reset enters CLEAR with clear counter 0.
REQ-018 CLEAR: one word written to 0 per cycle at counter index, counter increments; after index DEPTH_WORDS-1 is written, next state RUN; busy=1, req_ready=0 throughout.
REQ-019 RUN: req_ready = !rsp_valid || rsp_ready (one-entry response register, full throughput without backpressure).
REQ-020 Accepted request produces its response exactly one cycle later (rsp_valid registered); consecutive accepted requests produce back-to-back responses.
REQ-021 Word index = req_addr[ADDR_W-1:2]; byte lane = req_addr[1:0].
REQ-022 Error when: req_size=11; half with req_addr[0]=1; word with req_addr[1:0]!=0; word index >= DEPTH_WORDS.
REQ-023 Errored request: no memory write, rsp_err=1, rsp_rdata=0.
REQ-024 Store: byte enables derived from size and lane; only enabled bytes updated; req_wdata shifted to lane; rsp_err=0, rsp_rdata=0.
REQ-025 Load: selected bytes shifted to bit 0, extended per req_signed to 32 bits; word loads ignore req_signed.
REQ-026 Load after store to same word in the next accepted cycle SHALL return the stored data (write completes at acceptance edge).
REQ-027 Response held stable while rsp_valid && !rsp_ready; cleared to rsp_valid=0 when consumed with no new acceptance.
REQ-028 req_valid with req_ready=0 has no effect; requester holds request.

Reset
REQ-029 Asserted rst_n forces: state CLEAR, counter 0, busy 1, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Reset during CLEAR or RUN abandons in-flight response and restarts full sweep; memory contents after sweep all zero.
REQ-031 Memory array itself has no reset; it is zeroed only by the sweep.

Structure
REQ-032 Shared package dm_pkg: size encoding constants, byte-enable width, error-cause helper constants.
REQ-033 One combinational sub-module dm_lane_fmt: store shift and byte-enable generation, load extract and extension.
REQ-034 Storage is a single synchronous-write array of DEPTH_WORDS x 32; read path combinational from array into response register.

Verification
REQ-035 Reset release with DEPTH_WORDS=16 -> busy high exactly 16 cycles, req_ready rises the cycle busy falls; loads of all words return 0.
REQ-036 Store word 0x8899AABB at 0x10, load byte 0x13 signed -> 0xFFFFFF88; unsigned -> 0x00000088; half 0x10 signed -> 0xFFFFAABB.
REQ-037 Store byte 0x5A at 0x21 over word 0x11223344 at 0x20, load word 0x20 -> 0x11225A44.
REQ-038 Word load at 0x02, half at 0x03, size 11, word index DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-039 rsp_ready low 3 cycles with response pending -> req_ready low, rsp_rdata/rsp_err stable; then back-to-back loads at 1/cycle.
REQ-040 rst_n pulsed mid-RUN with response pending -> rsp_valid 0 immediately, busy 1, sweep restarts, prior data reads 0.
